// File: rtl/sample_seq_queue.sv
// Decimating circular sample queue that replays the latest TAPS samples, oldest first, to a FIR MAC.
// Define SSQ_SEQ_MARK_EN to add the seq_first/seq_last burst marker outputs.
module sample_seq_queue #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int TAPS       = 1021,
   parameter int DECIM      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              smpl_vld,
   input  logic [DATA_W-1:0] new_smpl,
   output logic [DATA_W-1:0] smpl_out,
   output logic              sequencing,
   output logic              full,
   output logic              overrun
`ifdef SSQ_SEQ_MARK_EN
   ,
   output logic              seq_first,
   output logic              seq_last
`endif
);

   localparam int DEPTH  = 2**DEPTH_LOG2;
   localparam int FILL_W = $clog2(TAPS + 1);
   localparam int IDX_W  = $clog2(TAPS);
   localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

   generate
      if (DEPTH < TAPS + 2) begin : g_depth_chk
         $error("sample_seq_queue: 2**DEPTH_LOG2 must be at least TAPS+2");
      end
      if (TAPS < 2 || DECIM < 1) begin : g_param_chk
         $error("sample_seq_queue: TAPS must be >= 2 and DECIM >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, READ} state_t;

   state_t                state, state_nxt;
   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DATA_W-1:0]     rd_dat;
   logic [DEPTH_LOG2-1:0] wr_ptr, base, win_start, rd_addr;
   logic [FILL_W-1:0]     fill;
   logic [DEC_W-1:0]      dec_cnt;
   logic [IDX_W-1:0]      rd_idx;
   logic                  accept, req, pending;
   logic                  rd_en, rd_first, rd_last, restart;

   assign accept    = smpl_vld && (dec_cnt == DEC_W'(DECIM - 1));
   // fill after this write reaches TAPS when it is already there or one short
   assign req       = accept && (fill >= FILL_W'(TAPS - 1));
   assign full      = (fill == FILL_W'(TAPS));
   assign win_start = wr_ptr - DEPTH_LOG2'(TAPS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_cnt <= '0;
         wr_ptr  <= '0;
         fill    <= '0;
      end else if (smpl_vld) begin
         dec_cnt <= accept ? '0 : dec_cnt + 1'b1;
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full) fill <= fill + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= new_smpl;
      if (rd_en)  rd_dat      <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = READ;
         READ:    if (rd_last && !(pending || req)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_en    = (state == READ);
      rd_first = rd_en && (rd_idx == '0);
      rd_last  = rd_en && (rd_idx == IDX_W'(TAPS - 1));
      restart  = rd_last && (pending || req);
      // first address comes straight from wr_ptr so a restart picks up the newest sample
      rd_addr  = rd_first ? win_start : base + DEPTH_LOG2'(rd_idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_idx <= '0;
         base   <= '0;
      end else begin
         if (rd_en)    rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
         if (rd_first) base   <= win_start;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (restart) begin
         pending <= 1'b0;
      end else if (req && rd_en) begin
         pending <= 1'b1;
         if (pending) overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sequencing <= 1'b0;
      else        sequencing <= rd_en;
   end

   assign smpl_out = sequencing ? rd_dat : '0;

`ifdef SSQ_SEQ_MARK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_first <= 1'b0;
         seq_last  <= 1'b0;
      end else begin
         seq_first <= rd_first;
         seq_last  <= rd_last;
      end
   end
`endif

endmodule

// File: tb/tb_sample_seq_queue.sv
// Bench for sample_seq_queue: two configurations, table-driven burst sequence, directed corners, random vs model.
module tb_sample_seq_queue;
   localparam int EN = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld = 1'b0;
   logic [15:0] dat = '0;
   logic [15:0] out_a, out_b;
   logic        seq_a, seq_b, full_a, full_b, ovr_a, ovr_b;
`ifdef SSQ_SEQ_MARK_EN
   logic        first_a, last_a, first_b, last_b;
`endif

   int nvec = 0;
   int nbad = 0;
   int cyc  = 0;
   logic [15:0] cap_q [$];
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   sample_seq_queue #(.DATA_W(16), .DEPTH_LOG2(3), .TAPS(4), .DECIM(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .smpl_vld(vld), .new_smpl(dat),
      .smpl_out(out_a), .sequencing(seq_a), .full(full_a), .overrun(ovr_a)
`ifdef SSQ_SEQ_MARK_EN
      , .seq_first(first_a), .seq_last(last_a)
`endif
   );

   sample_seq_queue #(.DATA_W(16), .DEPTH_LOG2(3), .TAPS(5), .DECIM(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .smpl_vld(vld), .new_smpl(dat),
      .smpl_out(out_b), .sequencing(seq_b), .full(full_b), .overrun(ovr_b)
`ifdef SSQ_SEQ_MARK_EN
      , .seq_first(first_b), .seq_last(last_b)
`endif
   );

   // reference model: sample history, burst schedule and per-cycle expected outputs
   int          m_strb [2];
   int          m_cnt [2];
   int          m_start [2];
   bit          m_pend [2];
   bit          m_ovr [2];
   logic [15:0] m_hist [2][0:EN-1];
   bit          e_seq [2][0:EN-1];
   logic [15:0] e_out [2][0:EN-1];
`ifdef SSQ_SEQ_MARK_EN
   bit          e_first [2][0:EN-1];
   bit          e_last [2][0:EN-1];
`endif

   function automatic int taps(input int i);
      return (i == 0) ? 4 : 5;
   endfunction

   function automatic int decim(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_strb[i] = 0; m_cnt[i] = 0; m_start[i] = -100; m_pend[i] = 0; m_ovr[i] = 0;
         for (int k = 0; k < EN; k++) begin
            e_seq[i][k] = 0;
            e_out[i][k] = '0;
`ifdef SSQ_SEQ_MARK_EN
            e_first[i][k] = 0;
            e_last[i][k]  = 0;
`endif
         end
      end
      cyc = 0;
   endtask

   task automatic mstep(input int i, input int c, input logic v, input logic [15:0] d);
      int t;
      bit in_rd, last, req;
      t     = taps(i);
      in_rd = (c >= m_start[i]) && (c < m_start[i] + t);
      last  = (c == m_start[i] + t - 1);
      req   = 0;
      if (c == m_start[i]) begin
         for (int k = 0; k < t; k++) begin
            if (c + 1 + k < EN) begin
               e_seq[i][c+1+k] = 1;
               e_out[i][c+1+k] = m_hist[i][m_cnt[i]-t+k];
`ifdef SSQ_SEQ_MARK_EN
               e_first[i][c+1+k] = (k == 0);
               e_last[i][c+1+k]  = (k == t - 1);
`endif
            end
         end
      end
      if (v) begin
         m_strb[i]++;
         if (m_strb[i] % decim(i) == 0) begin
            m_hist[i][m_cnt[i]] = d;
            m_cnt[i]++;
            req = (m_cnt[i] >= t);
         end
      end
      if (req && in_rd && !last) begin
         if (m_pend[i]) m_ovr[i] = 1;
         m_pend[i] = 1;
      end else if (req || (last && m_pend[i])) begin
         m_start[i] = c + 1;
         m_pend[i]  = 0;
      end
   endtask

   task automatic check_all();
      if (cyc >= EN) begin
         cmp("cycle_budget", cyc, EN - 1);
      end else begin
         cmp("a_seq", seq_a, e_seq[0][cyc]);
         cmp("a_out", out_a, e_seq[0][cyc] ? e_out[0][cyc] : 16'd0);
         cmp("a_full", full_a, m_cnt[0] >= 4);
         cmp("a_ovr", ovr_a, m_ovr[0]);
         cmp("b_seq", seq_b, e_seq[1][cyc]);
         cmp("b_out", out_b, e_seq[1][cyc] ? e_out[1][cyc] : 16'd0);
         cmp("b_full", full_b, m_cnt[1] >= 5);
         cmp("b_ovr", ovr_b, m_ovr[1]);
`ifdef SSQ_SEQ_MARK_EN
         cmp("a_first", first_a, e_first[0][cyc]);
         cmp("a_last", last_a, e_last[0][cyc]);
         cmp("b_first", first_b, e_first[1][cyc]);
         cmp("b_last", last_b, e_last[1][cyc]);
`endif
      end
   endtask

   // called at a negedge: check this cycle's outputs, then drive this cycle's inputs
   task automatic apply(input logic v, input logic [15:0] d);
      check_all();
      if (seq_a) cap_q.push_back(out_a);
      vld = v;
      dat = d;
      if (cyc < EN) begin
         mstep(0, cyc, v, d);
         mstep(1, cyc, v, d);
      end
      cyc++;
   endtask

   task automatic tick(input logic v, input logic [15:0] d);
      @(negedge clk);
      apply(v, d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      check_all();
      rst_n = 1'b0;
      vld   = 1'b0;
      #1;
      cmp("rst_a_out", out_a, 16'd0);
      cmp("rst_a_seq", seq_a, 1'b0);
      cmp("rst_a_full", full_a, 1'b0);
      cmp("rst_a_ovr", ovr_a, 1'b0);
      cmp("rst_b_seq", seq_b, 1'b0);
      cmp("rst_b_full", full_b, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cap_q.delete();
   endtask

   task automatic cmp_cap(input string nm);
      cmp({nm, "_len"}, cap_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
         cmp(nm, cap_q[k], exp_q[k]);
   endtask

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        seq;
      logic [15:0] out;
      logic        full;
      logic        f;
      logic        l;
   } row_t;

   row_t tbl [14];

   initial begin
      // strobes 1..4, then strobe 5 on the second sequencing cycle: two windows back-to-back
      tbl[0]  = '{1'b1, 16'd1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 16'd3, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'd4, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 16'd0, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 16'd5, 1'b1, 16'd2, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 16'd0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 16'd0, 1'b1, 16'd2, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 16'd0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 16'd0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};

      model_reset();
      do_reset();

      for (int r = 0; r < 14; r++) begin
         @(negedge clk);
         cmp("tbl_seq", seq_a, tbl[r].seq);
         cmp("tbl_out", out_a, tbl[r].out);
         cmp("tbl_full", full_a, tbl[r].full);
`ifdef SSQ_SEQ_MARK_EN
         cmp("tbl_first", first_a, tbl[r].f);
         cmp("tbl_last", last_a, tbl[r].l);
`endif
         apply(tbl[r].v, tbl[r].d);
      end
      cmp("tbl_ovr", ovr_a, 1'b0);

      // two requests during one burst: second is an overrun, next window is 3..6
      do_reset();
      for (int s = 1; s <= 4; s++) tick(1'b1, 16'(s));
      tick(1'b0, 16'd0);
      tick(1'b1, 16'd5);
      tick(1'b1, 16'd6);
      repeat (15) tick(1'b0, 16'd0);
      exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd4, 16'd5, 16'd6};
      cmp_cap("ovr_win");
      cmp("ovr_sticky", ovr_a, 1'b1);

      // reset on the second sequencing cycle aborts the burst; refill needs four new samples
      do_reset();
      for (int s = 1; s <= 4; s++) tick(1'b1, 16'(s));
      tick(1'b0, 16'd0);
      tick(1'b0, 16'd0);
      do_reset();
      for (int s = 7; s <= 10; s++) tick(1'b1, 16'(s));
      repeat (10) tick(1'b0, 16'd0);
      exp_q = '{16'd7, 16'd8, 16'd9, 16'd10};
      cmp_cap("rst_win");
      cmp("rst_ovr_clr", ovr_a, 1'b0);

      // spaced strobes 1..12 wrap the depth-8 RAM
      do_reset();
      for (int s = 1; s <= 12; s++) begin
         tick(1'b1, 16'(s));
         repeat (9) tick(1'b0, 16'd0);
      end
      exp_q.delete();
      for (int k = 4; k <= 12; k++)
         for (int j = k - 3; j <= k; j++) exp_q.push_back(16'(j));
      cmp_cap("wrap_win");

      // random traffic, sparse then dense, checked cycle by cycle against the model
      do_reset();
      for (int n = 0; n < 900; n++) begin
         if (n < 450) tick($urandom_range(0, 7) == 0, 16'($urandom));
         else         tick($urandom_range(0, 1) == 0, 16'($urandom));
      end
      repeat (20) tick(1'b0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
